mc14500_sys_p: RTL and testbench

- Parametrised 1-bit industrial-control computer.
- Contains an MC14500-compatible ICU, a bit-serial SRAM port, a scratch bit file, two output latches and a serial pin pair.
- Adds what the previous generation lacked: configurable PC/memory widths, a hardware return-address stack (call/return), and sticky stack-error reporting.
- Sits between the external program ROM (io_in) and the board SRAM/IO header.

---
 rtl/mc14500_sys_p.sv | 183 ++++++++++++++++++
 tb/tb_mc14500_sys_p.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mc14500_sys_p.sv
// MC14500-compatible 1-bit control computer: ICU, bit-serial SRAM port,
// scratch bit file, output latches and a circular return-address stack.
module mc14500_sys_p #(
    parameter int unsigned PC_W        = 17,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned MEM_DW      = 8
) (
    input  logic              i_clk,
    input  logic              rst,
    input  logic [7:0]        io_in,
    input  logic              sdi,
    input  logic [MEM_DW-1:0] sram_out,
    output logic [PC_W-1:0]   pc,
    output logic              phase,
    output logic              rr,
    output logic              flag_o,
    output logic              flag_f,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [MEM_DW-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sclk,
    output logic              sdo,
    output logic              out_1,
    output logic              out_2
);

    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [3:0] {
        OP_NOPO = 4'h0, OP_LD   = 4'h1, OP_LDC  = 4'h2, OP_AND  = 4'h3,
        OP_ANDC = 4'h4, OP_OR   = 4'h5, OP_ORC  = 4'h6, OP_XNOR = 4'h7,
        OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN  = 4'hA, OP_OEN  = 4'hB,
        OP_JMP  = 4'hC, OP_RTN  = 4'hD, OP_SKZ  = 4'hE, OP_NOPF = 4'hF
    } op_e;

    logic              ien;
    logic              oen;
    logic              skip;
    logic              err;
    logic [MEM_AW-1:0] mar;
    logic [MEM_DW-1:0] dob;
    logic [MEM_DW-1:0] dia;
    logic [PC_W-1:0]   dest;
    logic [7:0]        scratch;
    logic [PC_W-1:0]   stk [STACK_DEPTH];
    logic [CNT_W-1:0]  cnt;

    op_e               op;
    logic [3:0]        addr;
    logic              din;
    logic              data;
    logic              wbit;
    logic              active;
    logic              stk_empty;
    logic              stk_full;
    logic [PC_W-1:0]   pc_inc;

    assign op        = op_e'(io_in[3:0]);
    assign addr      = io_in[7:4];
    assign data      = din & ien;
    assign wbit      = (op == OP_STOC) ? ~rr : rr;
    assign active    = phase & ~skip & ~rst;
    assign stk_empty = (cnt == CNT_W'(0));
    assign stk_full  = (cnt == CNT_W'(STACK_DEPTH));
    assign pc_inc    = pc + PC_W'(1);

    // Execute-phase strobes are decoded straight from the instruction bus.
    assign flag_o  = active & (op == OP_NOPO);
    assign flag_f  = active & (op == OP_NOPF);
    assign sram_we = active & (op == OP_NOPF);

    assign sram_wdata = dob;
    assign sclk       = scratch[6];
    assign sdo        = scratch[7];

    // mar shifts in LSB-first, so the address pins see it bit-reversed.
    for (genvar g = 0; g < MEM_AW; g++) begin : g_rev
        assign sram_addr[g] = mar[MEM_AW-1-g];
    end

    // Input read map.
    always_comb begin
        din = 1'b0;
        case (addr)
            4'd0:    din = 1'b1;
            4'd1:    din = sdi;
            4'd2:    din = dia[MEM_DW-1];
            4'd3:    din = 1'b0;
            4'd4:    din = out_1;
            4'd5:    din = out_2;
            4'd6:    din = stk_empty;
            4'd7:    din = err;
            default: din = scratch[addr[2:0]];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            pc      <= '0;
            phase   <= 1'b0;
            rr      <= 1'b0;
            ien     <= 1'b0;
            oen     <= 1'b0;
            skip    <= 1'b0;
            err     <= 1'b0;
            mar     <= '0;
            dob     <= '0;
            dia     <= '0;
            dest    <= '0;
            scratch <= '0;
            cnt     <= '0;
            out_1   <= 1'b1;
            out_2   <= 1'b1;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stk[i] <= '0;
            end
        end else begin
            phase <= ~phase;
            if (phase) begin
                pc <= pc_inc;
                if (skip) begin
                    skip <= 1'b0;
                end else begin
                    case (op)
                        OP_NOPO: if (addr == 4'd1) dia <= sram_out;
                        OP_LD:   rr <= data;
                        OP_LDC:  rr <= ~data;
                        OP_AND:  rr <= rr & data;
                        OP_ANDC: rr <= rr & ~data;
                        OP_OR:   rr <= rr | data;
                        OP_ORC:  rr <= rr | ~data;
                        OP_XNOR: rr <= ~(rr ^ data);
                        OP_STO, OP_STOC: begin
                            if (oen) begin
                                case (addr)
                                    4'd0: dest  <= (dest << 1) | PC_W'(wbit);
                                    4'd1: mar   <= (mar << 1) | MEM_AW'(wbit);
                                    4'd2: dob   <= (dob << 1) | MEM_DW'(wbit);
                                    4'd4: out_1 <= wbit;
                                    4'd5: out_2 <= wbit;
                                    default: if (addr[3]) scratch[addr[2:0]] <= wbit;
                                endcase
                            end
                        end
                        OP_IEN: ien <= din;
                        OP_OEN: oen <= din;
                        OP_JMP: begin
                            pc <= dest;
                            // Call: newest entry at stk[0]; a full stack drops its oldest.
                            if (addr == 4'd1) begin
                                for (int i = int'(STACK_DEPTH) - 1; i > 0; i--) begin
                                    stk[i] <= stk[i-1];
                                end
                                stk[0] <= pc_inc;
                                if (stk_full) err <= 1'b1;
                                else          cnt <= cnt + CNT_W'(1);
                            end
                        end
                        OP_RTN: begin
                            mar <= '0;
                            if (stk_empty) begin
                                err <= 1'b1;
                            end else begin
                                pc <= stk[0];
                                for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) begin
                                    stk[i] <= stk[i+1];
                                end
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                        OP_SKZ: if (!rr) skip <= 1'b1;
                        default: ;
                    endcase
                    if ((op >= OP_LD) && (op <= OP_XNOR) && (addr == 4'd2)) begin
                        dia <= dia << 1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mc14500_sys_p.sv
// Directed self-checking bench for mc14500_sys_p (PC_W=4, STACK_DEPTH=2).
module tb_mc14500_sys_p;

    localparam logic [3:0] NOPO = 4'h0, LD = 4'h1, LDC = 4'h2, AND_ = 4'h3,
                           ANDC = 4'h4, OR_ = 4'h5, ORC = 4'h6, XNOR_ = 4'h7,
                           STO = 4'h8, STOC = 4'h9, IEN = 4'hA, OEN = 4'hB,
                           JMP = 4'hC, RTN = 4'hD, SKZ = 4'hE, NOPF = 4'hF;

    logic       i_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] io_in = 8'h30;
    logic       sdi = 1'b0;
    logic [7:0] sram_out = 8'h00;
    logic [3:0] pc;
    logic       phase, rr, flag_o, flag_f, sram_we, sclk, sdo, out_1, out_2;
    logic [7:0] sram_addr, sram_wdata;

    int checks = 0;
    int errors = 0;

    logic       ph_we, ph_fo, ph_ff;
    logic [7:0] ph_addr, ph_wdata;

    mc14500_sys_p #(.PC_W(4), .STACK_DEPTH(2), .MEM_AW(8), .MEM_DW(8)) dut (
        .i_clk(i_clk), .rst(rst), .io_in(io_in), .sdi(sdi), .sram_out(sram_out),
        .pc(pc), .phase(phase), .rr(rr), .flag_o(flag_o), .flag_f(flag_f),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
        .sclk(sclk), .sdo(sdo), .out_1(out_1), .out_2(out_2)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // One full instruction: fetch cycle, then execute cycle (phase-1 strobes captured).
    task automatic exec(input logic [3:0] a, input logic [3:0] op);
        io_in = {a, op};
        @(posedge i_clk); #1;
        ph_we = sram_we; ph_fo = flag_o; ph_ff = flag_f;
        ph_addr = sram_addr; ph_wdata = sram_wdata;
        @(posedge i_clk); #1;
        io_in = 8'h30;
    endtask

    task automatic do_reset();
        rst = 1'b1; io_in = 8'h30;
        repeat (2) @(posedge i_clk);
        #1 rst = 1'b0;
    endtask

    // Shift n bits MSB-first into a write-map target (rr must be 1).
    task automatic shift_in(input logic [3:0] a, input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exec(a, v[i] ? STO : STOC);
    endtask

    task automatic setup_io();
        exec(4'd0, IEN); exec(4'd0, OEN); exec(4'd0, LD);
    endtask

    task automatic test_reset();
        rst = 1'b1; io_in = {4'd0, NOPF};
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (pc !== 4'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc); end
        checks++; if (rr !== 1'b0) begin errors++; $display("FAIL reset_rr: got %b expected 0", rr); end
        checks++; if ({out_1, out_2} !== 2'b11) begin errors++; $display("FAIL reset_outs: got %b expected 11", {out_1, out_2}); end
        checks++; if ({sram_we, flag_f, phase} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {sram_we, flag_f, phase}); end
        io_in = 8'h30; rst = 1'b0;
        @(posedge i_clk); #1;
        checks++; if ({phase, pc} !== {1'b1, 4'h0}) begin errors++; $display("FAIL first_exec: got ph=%b pc=%h expected ph=1 pc=0", phase, pc); end
        @(posedge i_clk); #1;
        checks++; if ({phase, pc} !== {1'b0, 4'h1}) begin errors++; $display("FAIL first_inc: got ph=%b pc=%h expected ph=0 pc=1", phase, pc); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        exec(4'd0, IEN);
        io_in = {4'd3, LDC};
        @(posedge i_clk); #1;
        rst = 1'b1;
        @(posedge i_clk); #1;
        checks++; if ({rr, pc, phase} !== 6'b0) begin errors++; $display("FAIL abort: got rr=%b pc=%h ph=%b expected all 0", rr, pc, phase); end
        rst = 1'b0; io_in = 8'h30;
    endtask

    task automatic test_logic();
        logic [3:0] ops [10];
        logic [3:0] ads [10];
        logic       exp [10];
        do_reset();
        exec(4'd0, IEN);
        ops = '{LD, AND_, ORC, XNOR_, ANDC, OR_, XNOR_, LD, LDC, LD};
        ads = '{4'd0, 4'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd0, 4'd1};
        exp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        sdi = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) sdi = 1'b0;
            exec(ads[i], ops[i]);
            checks++; if (rr !== exp[i]) begin errors++; $display("FAIL logic_%0d: got rr=%b expected %b", i, rr, exp[i]); end
        end
        exec(4'd3, IEN);
        exec(4'd0, LDC);
        checks++; if (rr !== 1'b1) begin errors++; $display("FAIL ien_gate_ldc: got %b expected 1", rr); end
        setup_io();
        exec(4'd14, STO);
        checks++; if ({sdo, sclk} !== 2'b01) begin errors++; $display("FAIL scratch6: got sdo,sclk=%b expected 01", {sdo, sclk}); end
        exec(4'd15, STO);
        exec(4'd14, LDC);
        checks++; if ({sdo, rr} !== 2'b10) begin errors++; $display("FAIL scratch_rd: got sdo,rr=%b expected 10", {sdo, rr}); end
    endtask

    task automatic test_enables();
        do_reset();
        setup_io();
        exec(4'd4, STOC);
        checks++; if ({out_1, pc} !== {1'b0, 4'h4}) begin errors++; $display("FAIL latch_write: got out_1=%b pc=%h expected 0,4", out_1, pc); end
        do_reset();
        exec(4'd0, IEN); exec(4'd3, OEN); exec(4'd0, LD); exec(4'd4, STOC);
        checks++; if (out_1 !== 1'b1) begin errors++; $display("FAIL oen_block: got out_1=%b expected 1", out_1); end
    endtask

    task automatic test_skip();
        do_reset();
        exec(4'd0, IEN); exec(4'd0, OEN);
        exec(4'd0, LDC); exec(4'd0, SKZ); exec(4'd5, STO);
        checks++; if ({out_2, pc} !== {1'b1, 4'h5}) begin errors++; $display("FAIL skip_sto: got out_2=%b pc=%h expected 1,5", out_2, pc); end
        exec(4'd0, SKZ); exec(4'd0, NOPF);
        checks++; if ({ph_we, ph_ff} !== 2'b00) begin errors++; $display("FAIL skip_nopf: got we,f=%b expected 00", {ph_we, ph_ff}); end
        exec(4'd0, LD); exec(4'd0, SKZ); exec(4'd5, STOC);
        checks++; if ({out_2, pc} !== {1'b0, 4'hA}) begin errors++; $display("FAIL noskip: got out_2=%b pc=%h expected 0,a", out_2, pc); end
    endtask

    task automatic test_call_return();
        do_reset();
        setup_io();
        shift_in(4'd0, 8'h0C, 4);
        exec(4'd1, JMP);
        checks++; if (pc !== 4'hC) begin errors++; $display("FAIL call1: got pc=%h expected c", pc); end
        shift_in(4'd0, 8'h02, 4);
        exec(4'd1, JMP);
        checks++; if (pc !== 4'h2) begin errors++; $display("FAIL call2: got pc=%h expected 2", pc); end
        shift_in(4'd0, 8'h09, 4);
        exec(4'd1, JMP);
        checks++; if (pc !== 4'h9) begin errors++; $display("FAIL call3: got pc=%h expected 9", pc); end
        exec(4'd7, LDC);
        checks++; if (rr !== 1'b0) begin errors++; $display("FAIL err_overflow: got rr=%b expected 0 (err=1)", rr); end
        exec(4'd0, RTN);
        checks++; if (pc !== 4'h7) begin errors++; $display("FAIL rtn1: got pc=%h expected 7", pc); end
        exec(4'd0, RTN);
        checks++; if (pc !== 4'h1) begin errors++; $display("FAIL rtn2: got pc=%h expected 1", pc); end
        exec(4'd0, RTN);
        checks++; if (pc !== 4'h2) begin errors++; $display("FAIL rtn_empty: got pc=%h expected 2", pc); end
        exec(4'd7, LD);
        checks++; if (rr !== 1'b1) begin errors++; $display("FAIL err_sticky: got rr=%b expected 1", rr); end
        exec(4'd0, LDC); exec(4'd6, LD);
        checks++; if (rr !== 1'b1) begin errors++; $display("FAIL stk_empty: got rr=%b expected 1", rr); end
    endtask

    task automatic test_sram();
        logic [7:0] seq;
        seq = 8'hC3;
        do_reset();
        setup_io();
        shift_in(4'd1, 8'h5A, 8);
        shift_in(4'd2, 8'hC3, 8);
        exec(4'd0, NOPF);
        checks++; if ({ph_we, ph_ff, ph_fo} !== 3'b110) begin errors++; $display("FAIL nopf_strobe: got we,f,o=%b expected 110", {ph_we, ph_ff, ph_fo}); end
        checks++; if ({ph_addr, ph_wdata} !== 16'h5AC3) begin errors++; $display("FAIL nopf_bus: got addr=%h data=%h expected 5a c3", ph_addr, ph_wdata); end
        checks++; if (sram_we !== 1'b0) begin errors++; $display("FAIL we_width: got %b expected 0", sram_we); end
        exec(4'd1, STO);
        checks++; if (sram_addr !== 8'hAD) begin errors++; $display("FAIL addr_rev: got %h expected ad", sram_addr); end
        sram_out = 8'hC3;
        exec(4'd1, NOPO);
        sram_out = 8'h00;
        checks++; if (ph_fo !== 1'b1) begin errors++; $display("FAIL flag_o: got %b expected 1", ph_fo); end
        for (int i = 0; i < 8; i++) begin
            exec(4'd2, LD);
            checks++; if (rr !== seq[7-i]) begin errors++; $display("FAIL dia_shift_%0d: got rr=%b expected %b", i, rr, seq[7-i]); end
        end
        exec(4'd0, RTN);
        checks++; if (sram_addr !== 8'h00) begin errors++; $display("FAIL rtn_mar: got %h expected 00", sram_addr); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) exec(4'd3, NOPO);
        checks++; if (pc !== 4'hF) begin errors++; $display("FAIL pc_15: got %h expected f", pc); end
        exec(4'd3, NOPO);
        checks++; if (pc !== 4'h0) begin errors++; $display("FAIL pc_wrap: got %h expected 0", pc); end
        setup_io();
        shift_in(4'd0, 8'h1F, 5);
        exec(4'd0, JMP);
        checks++; if (pc !== 4'hF) begin errors++; $display("FAIL jmp_trunc: got %h expected f", pc); end
    endtask

    initial begin
        test_reset();
        test_reset_abort();
        test_logic();
        test_enables();
        test_skip();
        test_call_return();
        test_sram();
        test_pc_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
